// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the execute-stage divider: operand width, divide
// op encodings, special-result constants, divider FSM state encoding and a
// two's-complement negation helper.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    // op[1] selects remainder, op[0] selects unsigned
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Two's-complement negation modulo 2^XLEN
    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] x);
        return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring-division iteration.
//   rem       in  XLEN  partial remainder (always < divisor)
//   quot      in  XLEN  dividend bits still to shift in / quotient bits so far
//   divisor   in  XLEN  divisor magnitude
//   next_rem  out XLEN  partial remainder after this iteration
//   next_quot out XLEN  quot shifted left with the new quotient bit
// The trial subtract {rem, quot[31]} - {0, divisor} is a 33-bit ripple chain
// of full-adder cells with the subtrahend inverted and carry-in tied to 1.
// ---------------------------------------------------------------------------
module div_step
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quot
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] sub_b_n;
    logic [XLEN:0] trial;
    logic [XLEN:0] carry;
    logic          trial_neg;

    assign shifted  = {rem, quot[XLEN-1]};
    assign sub_b_n  = ~{1'b0, divisor};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < XLEN; i++) begin : g_fa
        assign trial[i]   = shifted[i] ^ sub_b_n[i] ^ carry[i];
        assign carry[i+1] = (shifted[i] & sub_b_n[i]) | (carry[i] & (shifted[i] ^ sub_b_n[i]));
    end

    // Top bit of the 33-bit difference is the sign; no carry-out needed
    assign trial[XLEN] = shifted[XLEN] ^ sub_b_n[XLEN] ^ carry[XLEN];
    assign trial_neg   = trial[XLEN];

    assign next_rem  = trial_neg ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign next_quot = {quot[XLEN-2:0], ~trial_neg};

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU (radix-2 restoring,
// one quotient bit per cycle).
//   clk       in  1     clock, rising edge
//   rst       in  1     asynchronous active-high reset
//   start     in  1     request, sampled only while idle
//   op        in  2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in  XLEN  rs1, captured on the accepting edge
//   divisor   in  XLEN  rs2, captured on the accepting edge
//   busy      out 1     high from the cycle after accept through the DONE cycle
//   done      out 1     one-cycle pulse, result valid in the same cycle
//   result    out XLEN  quotient or remainder, held until the next accept
//
// Handshake: a start seen at a rising edge while the FSM is IDLE is accepted
// and the operands are captured on that edge; start at any other time is
// ignored (no queuing, no abort). Completion is signalled by a single-cycle
// done pulse with result valid alongside it. Normal ops take 33 cycles from
// the accepting edge to done, divide-by-zero and signed overflow take 1. The
// next start can be accepted at the edge that ends the done cycle.
// ---------------------------------------------------------------------------
module div_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_t      state;
    logic            sel_rem;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] div_mag_q;
    logic [4:0]      count;
    logic            neg_q;
    logic            neg_r;

    // Operand conditioning for the accepting cycle
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            overflow;

    assign a_neg       = ~op[0] & dividend[XLEN-1];
    assign b_neg       = ~op[0] & divisor[XLEN-1];
    assign a_mag       = a_neg ? neg2(dividend) : dividend;
    assign b_mag       = b_neg ? neg2(divisor) : divisor;
    assign div_by_zero = (divisor == '0);
    assign overflow    = ~op[0] && (dividend == INT_MIN) && (divisor == '1);

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quot;

    div_step u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (div_mag_q),
        .next_rem  (step_rem),
        .next_quot (step_quot)
    );

    // Sign fixup; neg_q/neg_r are only ever set for signed ops on the
    // normal path, so special results pass through untouched.
    logic [XLEN-1:0] final_quot;
    logic [XLEN-1:0] final_rem;

    assign final_quot = neg_q ? neg2(quot_q) : quot_q;
    assign final_rem  = neg_r ? neg2(rem_q)  : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DIV_IDLE;
            sel_rem   <= 1'b0;
            rem_q     <= '0;
            quot_q    <= '0;
            div_mag_q <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        sel_rem <= op[1];
                        busy    <= 1'b1;
                        if (div_by_zero) begin
                            quot_q <= DIV_ZERO_Q;
                            rem_q  <= dividend;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            state  <= DIV_DONE;
                        end else if (overflow) begin
                            quot_q <= INT_MIN;
                            rem_q  <= '0;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            state  <= DIV_DONE;
                        end else begin
                            quot_q    <= a_mag;
                            rem_q     <= '0;
                            div_mag_q <= b_mag;
                            count     <= 5'd31;
                            neg_q     <= a_neg ^ b_neg;
                            neg_r     <= a_neg;
                            state     <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q  <= step_rem;
                    quot_q <= step_quot;
                    count  <= count - 5'd1;
                    if (count == 5'd0) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    result <= sel_rem ? final_rem : final_quot;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit: hand-computed vectors for every op, the
// divide-by-zero and overflow special cases, start pulses during a busy op,
// and an asynchronous reset in the middle of a calculation.
// ---------------------------------------------------------------------------
module tb_div_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // -------- clock --------
    always #5 clk = ~clk;

    // -------- comparison --------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // -------- driver: one operation, checks latency, result and busy --------
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1;
        start = 1'b0;
        // operands are free to change once accepted
        op = 2'($urandom_range(0, 3));
        dividend = $urandom;
        divisor = $urandom;
        check({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_q.pop_front());
        check({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
    endtask

    // -------- directed sequence --------
    initial begin
        int dones;
        logic [31:0] done_res;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // unsigned and signed arithmetic (back-to-back accepts)
        do_op("divu_100_7",   DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         33);
        do_op("remu_100_7",   DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          33);
        do_op("div_m7_2",     DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
        do_op("rem_m7_2",     DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
        do_op("rem_7_m2",     DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);
        do_op("div_7_m2",     DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
        do_op("div_m8_m3",    DIV_OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33);
        do_op("rem_m8_m3",    DIV_OP_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33);
        do_op("divu_max_1",   DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);
        do_op("remu_max_16",  DIV_OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          33);
        do_op("divu_min_m1",  DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
        do_op("div_min_1",    DIV_OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  33);

        // divide by zero
        do_op("divu_by0",     DIV_OP_DIVU, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1);
        do_op("rem_by0",      DIV_OP_REM,  32'h1234,       32'd0,          32'h1234,       1);
        do_op("div_m5_by0",   DIV_OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1);
        do_op("rem_m5_by0",   DIV_OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1);

        // signed overflow
        do_op("div_ovf",      DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        do_op("rem_ovf",      DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

        // start pulses while busy are ignored
        @(negedge clk);
        op = DIV_OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        done_res = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 20);
            op = DIV_OP_DIVU;
            dividend = 32'd50;
            divisor = 32'd5;
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                done_res = result;
            end
        end
        check("ignore_done_count", dones, 32'd1);
        check("ignore_done_result", done_res, 32'd14);
        repeat (5) @(posedge clk);
        #1;
        check("ignore_result_held", result, 32'd14);
        check("ignore_idle_busy", {31'b0, busy}, 32'd0);

        // asynchronous reset during CALC
        @(negedge clk);
        op = DIV_OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("rst_pre_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("rst_no_done", dones, 32'd0);
        check("rst_result_cleared", result, 32'd0);
        do_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
